// File: rtl/fc_pkg.sv
// Shared constants and FSM state encoding for the fine/coarse interval path.
package fc_pkg;

  // Fine interpolator resolution: 8 sub-phases per reference clock.
  localparam int FINE_PHASES = 8;
  localparam int FINE_BITS   = 3;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_RISE = 3'd1,
    ST_MEASURE   = 3'd2,
    ST_ACCUM     = 3'd3,
    ST_HOLD      = 3'd4
  } state_t;

endpackage

// File: rtl/interval_accumulator_if.sv
// Result readout bus of the interval accumulator.
//
// Handshake: the master raises result_valid and holds result_sum and overflow
// stable until a cycle in which result_ready is sampled high; that cycle is the
// transfer, and result_valid drops on the following cycle. Valid and ready may
// be high in the same cycle; ready may be held high in advance.
interface interval_accumulator_if #(
  parameter int ACC_W = 44
);
  logic [ACC_W-1:0] result_sum;
  logic             result_valid;
  logic             result_ready;
  logic             overflow;

  modport master (
    output result_sum,
    output result_valid,
    output overflow,
    input  result_ready
  );

  modport slave (
    input  result_sum,
    input  result_valid,
    input  overflow,
    output result_ready
  );
endinterface

// File: rtl/gate_sync_edge.sv
// Synchronizes the asynchronous sample_gate and emits one-cycle rise/fall
// pulses. Both edges see the same latency (SYNC_STAGES+1 clk), so it cancels
// out of any high-time measurement.
module gate_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic gate_i,
  output logic rise_det,
  output logic fall_det
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   rise_q;
  logic                   fall_q;
  logic                   gate_s;

  assign gate_s   = sync_q[SYNC_STAGES-1];
  assign rise_det = rise_q;
  assign fall_det = fall_q;

  // Synchronizer chain followed by a registered edge detector.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= (sync_q << 1) | SYNC_STAGES'(gate_i);
      prev_q <= gate_s;
      rise_q <= gate_s & ~prev_q;
      fall_q <= ~gate_s & prev_q;
    end
  end

endmodule

// File: rtl/interval_accumulator.sv
// Measures sample_gate high intervals in clk/8 units (coarse count plus fine
// rise/fall codes), sums NUM_AVG of them and offers the sum on a valid/ready bus.
module interval_accumulator
  import fc_pkg::*;
#(
  parameter int COARSE_W    = 24,
  parameter int FINE_BITS   = fc_pkg::FINE_BITS,
  parameter int NUM_AVG     = 16,
  parameter int ACC_W       = 44,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   sample_gate,
  input  logic [FINE_BITS-1:0]   rise_code,
  input  logic [FINE_BITS-1:0]   fall_code,
  interval_accumulator_if.master res,
  output logic                   busy,
  output state_t                 dbg_state
);

  // n counts 0..NUM_AVG, so it needs one bit more than log2(NUM_AVG).
  localparam int NW = $clog2(NUM_AVG) + 1;
  localparam logic [COARSE_W-1:0] COARSE_MAX = {COARSE_W{1'b1}};

  logic rise_det;
  logic fall_det;

  state_t               state_q, state_d;
  logic [COARSE_W-1:0]  coarse_q, coarse_d;
  logic [FINE_BITS-1:0] rise_code_q, rise_code_d;
  logic [FINE_BITS-1:0] fall_code_q, fall_code_d;
  logic [ACC_W-1:0]     acc_q, acc_d;
  logic [NW-1:0]        n_q, n_d;
  logic                 ovf_q, ovf_d;

  logic [COARSE_W-1:0]  coarse_inc;
  logic [ACC_W-1:0]     interval;
  logic [NW-1:0]        n_inc;

  gate_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .reset    (reset),
    .gate_i   (sample_gate),
    .rise_det (rise_det),
    .fall_det (fall_det)
  );

  // Saturating coarse increment; coarse is at least 1 in ACCUM, so interval
  // can never go negative even when fall_code exceeds rise_code.
  assign coarse_inc = (coarse_q == COARSE_MAX) ? coarse_q : coarse_q + COARSE_W'(1);
  assign interval   = ACC_W'({coarse_q, {FINE_BITS{1'b0}}})
                    + ACC_W'(rise_code_q) - ACC_W'(fall_code_q);
  assign n_inc      = n_q + NW'(1);

  assign res.result_sum   = acc_q;
  assign res.result_valid = (state_q == ST_HOLD);
  assign res.overflow     = ovf_q;
  assign busy             = (state_q != ST_IDLE);
  assign dbg_state        = state_q;

  // Next-state and datapath update for the measurement FSM.
  always_comb begin
    state_d     = state_q;
    coarse_d    = coarse_q;
    rise_code_d = rise_code_q;
    fall_code_d = fall_code_q;
    acc_d       = acc_q;
    n_d         = n_q;
    ovf_d       = ovf_q;
    case (state_q)
      ST_IDLE: begin
        acc_d = '0;
        n_d   = '0;
        ovf_d = 1'b0;
        if (enable) state_d = ST_WAIT_RISE;
      end
      ST_WAIT_RISE: begin
        if (!enable) begin
          state_d = ST_IDLE;
          acc_d   = '0;
          n_d     = '0;
          ovf_d   = 1'b0;
        end else if (rise_det) begin
          state_d     = ST_MEASURE;
          coarse_d    = '0;
          rise_code_d = rise_code;
        end
      end
      ST_MEASURE: begin
        if (!enable) begin
          state_d = ST_IDLE;
          acc_d   = '0;
          n_d     = '0;
          ovf_d   = 1'b0;
        end else begin
          // The cycle carrying fall_det also counts, so a K-cycle gate gives K.
          coarse_d = coarse_inc;
          if (coarse_q == COARSE_MAX) ovf_d = 1'b1;
          if (fall_det) begin
            fall_code_d = fall_code;
            state_d     = ST_ACCUM;
          end
        end
      end
      ST_ACCUM: begin
        if (!enable) begin
          state_d = ST_IDLE;
          acc_d   = '0;
          n_d     = '0;
          ovf_d   = 1'b0;
        end else begin
          acc_d   = acc_q + interval;
          n_d     = n_inc;
          state_d = (n_inc == NW'(NUM_AVG)) ? ST_HOLD : ST_WAIT_RISE;
        end
      end
      ST_HOLD: begin
        // Enable is deliberately not checked: a completed result is always delivered.
        if (res.result_ready) begin
          acc_d   = '0;
          n_d     = '0;
          ovf_d   = 1'b0;
          state_d = enable ? ST_WAIT_RISE : ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      coarse_q    <= '0;
      rise_code_q <= '0;
      fall_code_q <= '0;
      acc_q       <= '0;
      n_q         <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      coarse_q    <= coarse_d;
      rise_code_q <= rise_code_d;
      fall_code_q <= fall_code_d;
      acc_q       <= acc_d;
      n_q         <= n_d;
      ovf_q       <= ovf_d;
    end
  end

endmodule

// File: tb/tb_interval_accumulator.sv
// Directed bench: three accumulator instances share the gate and fine codes;
// each has its own enable/ready so only the one under test reacts.
module tb_interval_accumulator;
  import fc_pkg::*;

  // Clock and reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       gate;
  logic [2:0] rcode;
  logic [2:0] fcode;
  logic       en1, en4, enc;
  logic       busy1, busy4, busyc;
  state_t     st1, st4, stc;

  int n_pass  = 0;
  int n_total = 0;

  interval_accumulator_if #(.ACC_W(44)) if1 ();
  interval_accumulator_if #(.ACC_W(44)) if4 ();
  interval_accumulator_if #(.ACC_W(44)) ifc ();

  interval_accumulator #(
    .COARSE_W(24), .FINE_BITS(3), .NUM_AVG(1), .ACC_W(44), .SYNC_STAGES(2)
  ) dut1 (
    .clk(clk), .reset(reset), .enable(en1), .sample_gate(gate),
    .rise_code(rcode), .fall_code(fcode), .res(if1.master),
    .busy(busy1), .dbg_state(st1)
  );

  interval_accumulator #(
    .COARSE_W(24), .FINE_BITS(3), .NUM_AVG(4), .ACC_W(44), .SYNC_STAGES(2)
  ) dut4 (
    .clk(clk), .reset(reset), .enable(en4), .sample_gate(gate),
    .rise_code(rcode), .fall_code(fcode), .res(if4.master),
    .busy(busy4), .dbg_state(st4)
  );

  interval_accumulator #(
    .COARSE_W(4), .FINE_BITS(3), .NUM_AVG(1), .ACC_W(44), .SYNC_STAGES(2)
  ) dutc (
    .clk(clk), .reset(reset), .enable(enc), .sample_gate(gate),
    .rise_code(rcode), .fall_code(fcode), .res(ifc.master),
    .busy(busyc), .dbg_state(stc)
  );

  // Driver tasks
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int k);
    gate = 1'b1;
    tick(k);
    gate = 1'b0;
  endtask

  // Checker
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  initial begin
    reset = 1'b0;
    gate  = 1'b0;
    rcode = '0;
    fcode = '0;
    en1 = 1'b0; en4 = 1'b0; enc = 1'b0;
    if1.result_ready = 1'b0;
    if4.result_ready = 1'b0;
    ifc.result_ready = 1'b0;
    tick(3);
    chk("rst_sum",   64'(if1.result_sum), 64'd0);
    chk("rst_valid", 64'(if1.result_valid), 64'd0);
    chk("rst_ovf",   64'(if1.overflow), 64'd0);
    chk("rst_busy",  64'(busy1), 64'd0);
    chk("rst_state", 64'(st1), 64'(ST_IDLE));
    reset = 1'b1;
    tick(2);

    // Single interval: 10 clk, codes 3/1 -> 82
    en1 = 1'b1;
    tick(2);
    chk("t1_busy",  64'(busy1), 64'd1);
    chk("t1_state", 64'(st1), 64'(ST_WAIT_RISE));
    rcode = 3'd3; fcode = 3'd1;
    pulse(10);
    tick(4);
    chk("t1_valid_early", 64'(if1.result_valid), 64'd0);
    tick(1);
    chk("t1_valid", 64'(if1.result_valid), 64'd1);
    chk("t1_sum",   64'(if1.result_sum), 64'd82);
    chk("t1_ovf",   64'(if1.overflow), 64'd0);

    // Backpressure: 3 pulses during 20 clk of ready low are ignored
    repeat (3) begin
      pulse(3);
      tick(3);
    end
    tick(2);
    chk("bp_valid_held", 64'(if1.result_valid), 64'd1);
    chk("bp_sum_held",   64'(if1.result_sum), 64'd82);
    if1.result_ready = 1'b1;
    #1;
    chk("bp_valid_xfer", 64'(if1.result_valid), 64'd1);
    tick(1);
    if1.result_ready = 1'b0;
    chk("bp_valid_drop", 64'(if1.result_valid), 64'd0);
    chk("bp_sum_clear",  64'(if1.result_sum), 64'd0);
    chk("bp_rearm",      64'(st1), 64'(ST_WAIT_RISE));
    tick(10);
    chk("bp_no_extra",   64'(if1.result_valid), 64'd0);

    // Abort mid-MEASURE, then a clean 4 clk pulse -> 32
    rcode = 3'd0; fcode = 3'd0;
    gate = 1'b1;
    tick(6);
    chk("ab_measure", 64'(st1), 64'(ST_MEASURE));
    en1 = 1'b0;
    tick(1);
    chk("ab_idle",  64'(busy1), 64'd0);
    chk("ab_valid", 64'(if1.result_valid), 64'd0);
    tick(3);
    gate = 1'b0;
    tick(8);
    chk("ab_valid_late", 64'(if1.result_valid), 64'd0);
    en1 = 1'b1;
    tick(2);
    pulse(4);
    tick(5);
    chk("ab_valid2", 64'(if1.result_valid), 64'd1);
    chk("ab_sum2",   64'(if1.result_sum), 64'd32);
    if1.result_ready = 1'b1;
    en1 = 1'b0;
    tick(1);
    if1.result_ready = 1'b0;
    chk("ab_to_idle", 64'(busy1), 64'd0);

    // NUM_AVG=4: 5+6+7+8 clk, codes 0 -> 208
    en4 = 1'b1;
    tick(2);
    pulse(5); tick(4);
    pulse(6); tick(4);
    pulse(7); tick(4);
    chk("avg_partial_valid", 64'(if4.result_valid), 64'd0);
    chk("avg_partial_busy",  64'(busy4), 64'd1);
    pulse(8);
    tick(4);
    chk("avg_valid_early", 64'(if4.result_valid), 64'd0);
    tick(1);
    chk("avg_valid", 64'(if4.result_valid), 64'd1);
    chk("avg_sum",   64'(if4.result_sum), 64'd208);
    chk("avg_ovf",   64'(if4.overflow), 64'd0);
    if4.result_ready = 1'b1;
    en4 = 1'b0;
    tick(1);
    if4.result_ready = 1'b0;
    chk("avg_idle", 64'(busy4), 64'd0);

    // COARSE_W=4: 20 clk saturates at 15 -> 15*8+5-2 = 123, overflow
    enc = 1'b1;
    tick(2);
    rcode = 3'd5; fcode = 3'd2;
    pulse(20);
    tick(5);
    chk("sat_valid", 64'(ifc.result_valid), 64'd1);
    chk("sat_sum",   64'(ifc.result_sum), 64'd123);
    chk("sat_ovf",   64'(ifc.overflow), 64'd1);
    ifc.result_ready = 1'b1;
    tick(1);
    ifc.result_ready = 1'b0;
    chk("sat_ovf_clear", 64'(ifc.overflow), 64'd0);
    chk("sat_sum_clear", 64'(ifc.result_sum), 64'd0);
    rcode = 3'd0; fcode = 3'd0;
    tick(2);
    pulse(6);
    tick(5);
    chk("sat_next_sum", 64'(ifc.result_sum), 64'd48);
    chk("sat_next_ovf", 64'(ifc.overflow), 64'd0);
    ifc.result_ready = 1'b1;
    tick(1);
    ifc.result_ready = 1'b0;

    // Reset during MEASURE
    en1 = 1'b1;
    tick(2);
    gate = 1'b1;
    tick(6);
    chk("rm_measure", 64'(st1), 64'(ST_MEASURE));
    reset = 1'b0;
    #1;
    chk("rm_busy",   64'(busy1), 64'd0);
    chk("rm_valid",  64'(if1.result_valid), 64'd0);
    chk("rm_busy_c", 64'(busyc), 64'd0);
    gate = 1'b0;
    tick(3);
    reset = 1'b1;
    tick(8);

    // Reset during HOLD (dutc carries a set overflow flag)
    rcode = 3'd1; fcode = 3'd0;
    pulse(20);
    tick(5);
    chk("rh_valid1", 64'(if1.result_valid), 64'd1);
    chk("rh_sum1",   64'(if1.result_sum), 64'd161);
    chk("rh_sumc",   64'(ifc.result_sum), 64'd121);
    chk("rh_ovfc",   64'(ifc.overflow), 64'd1);
    reset = 1'b0;
    #1;
    chk("rh_valid1_0", 64'(if1.result_valid), 64'd0);
    chk("rh_sum1_0",   64'(if1.result_sum), 64'd0);
    chk("rh_validc_0", 64'(ifc.result_valid), 64'd0);
    chk("rh_sumc_0",   64'(ifc.result_sum), 64'd0);
    chk("rh_ovfc_0",   64'(ifc.overflow), 64'd0);
    chk("rh_busyc_0",  64'(busyc), 64'd0);
    tick(2);
    reset = 1'b1;
    tick(3);

    // Normal measurement after release: 7*8+2-6 = 52
    rcode = 3'd2; fcode = 3'd6;
    pulse(7);
    tick(5);
    chk("post_valid1", 64'(if1.result_valid), 64'd1);
    chk("post_sum1",   64'(if1.result_sum), 64'd52);
    chk("post_sumc",   64'(ifc.result_sum), 64'd52);
    chk("post_ovfc",   64'(ifc.overflow), 64'd0);

    // Final report
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
